// File: rtl/instruction_loader.sv
// Serial program loader: frames a byte stream into little-endian 32-bit words,
// writes them to instruction memory and releases the core on a good checksum.
module instruction_loader #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [7:0]              csum_q, csum_d;
    logic [1:0]              idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             words_q, words_d;

    logic                    accept;
    logic [15:0]             len_full;
    logic [15:0]             words_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            words_q <= words_d;
        end
    end

    // Ready is purely a function of state so a stalled WRITE cycle never drops a byte.
    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: byte_ready = 1'b1;
            default:                           byte_ready = 1'b0;
        endcase
    end

    assign accept    = byte_valid && byte_ready;
    assign len_full  = {byte_data, len_q[7:0]};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        words_d = words_q;

        // The checksum byte itself is compared, never folded in.
        if (accept && (state_q != S_CHK)) begin
            csum_d = csum_q ^ byte_data;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    csum_d  = '0;
                    words_d = '0;
                    idx_d   = '0;
                    addr_d  = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = byte_data;
                    if ({1'b0, len_full} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                addr_d  = addr_q + ADDR_WIDTH'(4);
                state_d = (words_inc == len_q) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_we      = (state_q == S_WRITE);
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign core_reset   = (state_q != S_DONE);

    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK: busy = 1'b1;
            default:                                    busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: framed loads, checksum/oversize errors,
// backpressure with an ignored start, and asynchronous reset mid-load.
module tb_instruction_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int ready_viol = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    instruction_loader #(.DEPTH(256), .ADDR_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (byte_ready) ready_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit start_in_gap);
        int wait_cnt;
        if (gap) begin
            byte_valid = 1'b0;
            start      = start_in_gap;
            @(posedge clock); #1;
            start      = 1'b0;
        end
        byte_data  = b;
        byte_valid = 1'b1;
        wait_cnt   = 0;
        while (!byte_ready && wait_cnt < 50) begin
            @(posedge clock); #1;
            wait_cnt++;
        end
        if (wait_cnt >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bl[$], input bit toggle, input int start_at);
        for (int i = 0; i < bl.size(); i++) begin
            send_byte(bl[i], toggle, (i == start_at));
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_viol = 0;
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"}, wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], 32'h0);
            check({tag, "_d0"}, wr_data[0], 32'h00500093);
            check({tag, "_a1"}, wr_addr[1], 32'h4);
            check({tag, "_d1"}, wr_data[1], 32'h00A00113);
        end
        check({tag, "_rdy_in_write"}, ready_viol, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    imem_we,      1'b0);
        check({tag, "_addr"},  imem_addr,    32'h0);
        check({tag, "_wdata"}, imem_wdata,   32'h0);
        check({tag, "_crst"},  core_reset,   1'b1);
        check({tag, "_rdy"},   byte_ready,   1'b0);
        check({tag, "_busy"},  busy,         1'b0);
        check({tag, "_done"},  done,         1'b0);
        check({tag, "_err"},   error,        1'b0);
        check({tag, "_words"}, words_loaded, 16'd0);
    endtask

    logic [7:0] good_img[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    logic [7:0] bad_img[$]  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                8'h13, 8'h01, 8'hA0, 8'h00, 8'h74};
    logic [7:0] empty_img[$] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] big_img[$]   = '{8'h01, 8'h01};
    logic [7:0] first_word[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};

    initial begin
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        check_reset_outputs("por");
        #20;
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: two-word load, valid held high
        clear_log();
        pulse_start();
        check("s1_busy", busy, 1'b1);
        check("s1_crst_busy", core_reset, 1'b1);
        send_list(good_img, 1'b0, -1);
        check_two_writes("s1");
        check("s1_done", done, 1'b1);
        check("s1_err", error, 1'b0);
        check("s1_crst", core_reset, 1'b0);
        check("s1_busy_end", busy, 1'b0);
        check("s1_words", words_loaded, 16'd2);
        check("s1_rdy_done", byte_ready, 1'b0);

        // 2: checksum mismatch
        clear_log();
        pulse_start();
        check("s2_done_cleared", done, 1'b0);
        send_list(bad_img, 1'b0, -1);
        check_two_writes("s2");
        check("s2_err", error, 1'b1);
        check("s2_done", done, 1'b0);
        check("s2_crst", core_reset, 1'b1);

        // 3: empty image
        clear_log();
        pulse_start();
        check("s3_err_cleared", error, 1'b0);
        send_list(empty_img, 1'b0, -1);
        check("s3_nwr", wr_addr.size(), 0);
        check("s3_done", done, 1'b1);
        check("s3_words", words_loaded, 16'd0);

        // 4: oversize word count
        clear_log();
        pulse_start();
        send_list(big_img, 1'b0, -1);
        check("s4_err", error, 1'b1);
        check("s4_rdy", byte_ready, 1'b0);
        check("s4_busy", busy, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        check("s4_nwr", wr_addr.size(), 0);
        check("s4_err_hold", error, 1'b1);

        // 5: backpressure with a start pulse mid-load
        clear_log();
        pulse_start();
        send_list(good_img, 1'b1, 5);
        check_two_writes("s5");
        check("s5_done", done, 1'b1);
        check("s5_crst", core_reset, 1'b0);
        check("s5_words", words_loaded, 16'd2);

        // 6: async reset during the first write
        clear_log();
        pulse_start();
        send_list(first_word, 1'b0, -1);
        n = 0;
        while (wr_addr.size() < 1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("s6_first_write", wr_addr.size(), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("s6_rst");
        @(posedge clock); #1;
        reset = 1'b0;
        clear_log();
        pulse_start();
        send_list(good_img, 1'b0, -1);
        check_two_writes("s6_reload");
        check("s6_done", done, 1'b1);
        check("s6_words", words_loaded, 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Writer side of the instruction-memory read path: it fills instruction memory from a serial byte stream before the single-cycle datapath fetches from it. The block accepts a framed program image over a valid/ready byte handshake and assembles little-endian 32-bit words. It writes each word to consecutive word-aligned addresses and checks an XOR checksum. It holds the core in reset until a load completes successfully.

Parameters:
DEPTH, 256, instruction memory capacity in 32-bit words; maximum accepted word count.
ADDR_WIDTH, 32, width of imem_addr (byte address).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse; begins a new load.
byte_data  input  8  incoming stream byte.
byte_valid  input  1  byte_data is valid this cycle.
byte_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  instruction-memory write enable, one cycle per word.
imem_addr  output  ADDR_WIDTH  byte address of the write; always a multiple of 4.
imem_wdata  output  32  assembled instruction word.
core_reset  output  1  holds the datapath in reset while high.
busy  output  1  load in progress.
done  output  1  last load completed with a good checksum.
error  output  1  last load failed (checksum mismatch or oversize).
words_loaded  output  16  number of words written in the current or last load.

Behaviour:
- Reset (async): state IDLE, core_reset=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0, internal checksum=0, byte index=0, word count N=0.
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count, little-endian), then 4*N data bytes (each word LSB first), then one checksum byte. The checksum byte equals the XOR of all preceding frame bytes.
- Byte transfer: a byte is taken only when byte_valid=1 and byte_ready=1 on a rising edge.
- byte_ready=1 only in LEN_LO, LEN_HI, DATA and CHK. It is 0 in IDLE, WRITE, DONE and ERR.
- Every accepted byte except the checksum byte is XORed into the running checksum.
- IDLE / DONE / ERR: on start -> LEN_LO. Entering LEN_LO clears checksum, words_loaded, byte index, imem_addr and done/error, and sets busy=1 and core_reset=1.
- start is ignored while busy=1.
- LEN_LO: accept a byte into N[7:0] -> LEN_HI.
- LEN_HI: accept a byte into N[15:8], then:
  - If N > DEPTH -> ERR; no memory writes occur.
  - Else if N = 0 -> CHK.
  - Else -> DATA.
- DATA: accepted byte k (k=0..3) goes into imem_wdata[8k+7:8k]. After the 4th byte -> WRITE.
- WRITE: exactly one cycle with imem_we=1, imem_addr = 4*words_loaded and imem_wdata holding the assembled word. At the next edge words_loaded increments.
  - If the new words_loaded = N -> CHK.
  - Else -> DATA.
- Word latency: the write occurs in the cycle after the 4th byte of a word is accepted.
- CHK: accept one byte.
  - If it equals the running checksum -> DONE.
  - Else -> ERR.
- DONE: busy=0, done=1, core_reset=0. The block stays here until start or reset.
- ERR: busy=0, error=1, core_reset=1; the core stays halted. Words already written are not rolled back.
- imem_we is 0 in every state other than WRITE.
- Address arithmetic: imem_addr is zero-extended 4*words_loaded. It never wraps, because N ≤ DEPTH.
- Reset mid-load: returns immediately to the reset values. Memory contents already written remain as they are.

Test Plan:
1. Two-word load: start, then bytes 02 00 93 00 50 00 13 01 A0 00 73 with valid held high -> two writes: addr 0x0 data 0x00500093, addr 0x4 data 0x00A00113. Then done=1, core_reset=0, words_loaded=2, byte_ready=0 during each WRITE cycle.
2. Bad checksum: same stream with final byte 0x74 -> both writes occur, then error=1, done=0, core_reset=1.
3. Empty image: bytes 00 00 00 -> no imem_we pulses; done=1, words_loaded=0.
4. Oversize: bytes 01 01 (N=257 > DEPTH=256) -> ERR right after the second byte; no writes, byte_ready=0, error=1.
5. Backpressure: scenario 1 with byte_valid toggling every other cycle and start pulsed mid-load -> identical writes and result; start ignored.
6. Async reset asserted after the first WRITE of scenario 1 -> all outputs at reset values within the same cycle. A subsequent full scenario-1 load succeeds.
